// File: rtl/keccak_pkg.sv
// keccak_pkg: shared definitions for the Keccak pad feeder.
//   cmode_e     - hash mode encoding as seen on cmode_i
//   state_e     - feeder FSM states
//   DOM_SHA3    - SHA3 domain/pad byte (DOM_SHAKE when KECCAK_PAD_SHAKE_EN is defined)
//   rate_lanes  - rate of a mode in 64-bit lanes
//   mode_legal  - whether a cmode_i value may start a message
// Optional feature: KECCAK_PAD_SHAKE_EN enables SHAKE128/SHAKE256.
package keccak_pkg;

  typedef enum logic [2:0] {
    CM_SHA3_224 = 3'd0,
    CM_SHA3_256 = 3'd1,
    CM_SHA3_384 = 3'd2,
    CM_SHA3_512 = 3'd3,
    CM_SHAKE128 = 3'd4,
    CM_SHAKE256 = 3'd5
  } cmode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ABSORB,
    ST_PAD,
    ST_DONE
  } state_e;

  localparam logic [7:0] DOM_SHA3 = 8'h06;
`ifdef KECCAK_PAD_SHAKE_EN
  localparam logic [7:0] DOM_SHAKE = 8'h1F;
`endif

  function automatic logic [6:0] rate_lanes(input cmode_e m);
    case (m)
      CM_SHA3_224: return 7'd18;
      CM_SHA3_256: return 7'd17;
      CM_SHA3_384: return 7'd13;
      CM_SHA3_512: return 7'd9;
      CM_SHAKE128: return 7'd21;
      CM_SHAKE256: return 7'd17;
      default:     return 7'd17;
    endcase
  endfunction

  function automatic logic mode_legal(input logic [2:0] m);
`ifdef KECCAK_PAD_SHAKE_EN
    return (m <= 3'd5);
`else
    return (m <= 3'd3);
`endif
  endfunction

endpackage

// File: rtl/keccak_lane_packer.sv
// keccak_lane_packer: builds one 64-bit lane from two 32-bit halves and
// optionally inserts the pad byte and the final-lane bit 63.
//   lo_i/hi_i   - lane bits 31:0 / 63:32 (byte 0 = lo_i[7:0])
//   pad_en_i    - insert domain_i at byte pad_pos_i, zero every byte above it
//   pad_pos_i   - byte index 0..7 of the pad byte
//   domain_i    - domain/pad byte value
//   msb_i       - OR a 1 into bit 63 (last lane of the final block)
//   lane_o      - packed lane
module keccak_lane_packer (
  input  logic [31:0] lo_i,
  input  logic [31:0] hi_i,
  input  logic        pad_en_i,
  input  logic [2:0]  pad_pos_i,
  input  logic [7:0]  domain_i,
  input  logic        msb_i,
  output logic [63:0] lane_o
);

  always_comb begin
    lane_o = {hi_i, lo_i};
    if (pad_en_i) begin
      for (int b = 0; b < 8; b++) begin
        if (3'(b) == pad_pos_i) begin
          lane_o[b*8 +: 8] = domain_i;
        end else if (3'(b) > pad_pos_i) begin
          lane_o[b*8 +: 8] = 8'h00;
        end
      end
    end
    // Pad byte in byte 7 merges with the final bit: 0x06 -> 0x86, 0x1F -> 0x9F.
    lane_o[63] = lane_o[63] | msb_i;
  end

endmodule

// File: rtl/keccak_pad_feeder.sv
// keccak_pad_feeder: packs 32-bit message words into 64-bit Keccak lanes and
// appends pad10*1 padding with the mode's domain byte, one lane per handshake.
//   clk_i, reset_i                 - clock, synchronous active-high reset
//   start_i, cmode_i               - begin a message in the given mode
//   in_data_i/in_valid_i/in_last_i/in_nbytes_i/in_ready_o - word input
//   dout_0_o/dout_1_o/out_valid_o/out_ready_i             - lane output
//   out_block_end_o, last_block_o, last_block_count_o     - block framing
//   busy_o, err_o                  - message active, illegal mode requested
// Optional feature: KECCAK_PAD_SHAKE_EN makes cmode 4/5 (SHAKE) legal.
//
// state     | meaning
// ST_IDLE   | waiting for start_i
// ST_ABSORB | accepting message words, two per lane
// ST_PAD    | emitting pad / zero lanes up to the end of the final block
// ST_DONE   | waiting for the final lane to be taken
module keccak_pad_feeder
  import keccak_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [2:0]  cmode_i,
  input  logic [31:0] in_data_i,
  input  logic        in_valid_i,
  input  logic        in_last_i,
  input  logic [2:0]  in_nbytes_i,
  output logic        in_ready_o,
  output logic [31:0] dout_0_o,
  output logic [31:0] dout_1_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        out_block_end_o,
  output logic        last_block_o,
  output logic [6:0]  last_block_count_o,
  output logic        busy_o,
  output logic        err_o
);

  state_e      st_q;
  cmode_e      mode_q;
  logic        err_q;
  logic [31:0] lo_q;
  logic        lo_vld_q;
  logic [2:0]  nb_q;
  logic        pend_q;   // message filled its last lane exactly; pad byte goes in next lane
  logic        fin_q;    // last lane of the final block already loaded
  logic [6:0]  cnt_q;
  logic [63:0] out_q;
  logic        out_vld_q, out_end_q, out_lb_q;

  logic [6:0]  rate;
  logic        at_end, out_free, acc;
  logic [2:0]  nb_c;
  logic        load, fin_lane, pad_en;
  logic [2:0]  pad_pos;
  logic [31:0] pk_lo, pk_hi;
  logic [7:0]  dom;
  logic [63:0] lane;

  assign rate     = rate_lanes(mode_q);
  assign at_end   = (cnt_q == rate - 7'd1);
  assign nb_c     = (in_nbytes_i > 3'd4) ? 3'd4 : in_nbytes_i;
  assign out_free = !out_vld_q || out_ready_i;
  assign in_ready_o = (st_q == ST_ABSORB) && (!lo_vld_q || out_free);
  assign acc      = in_valid_i && in_ready_o;

`ifdef KECCAK_PAD_SHAKE_EN
  assign dom = (mode_q == CM_SHAKE128 || mode_q == CM_SHAKE256) ? DOM_SHAKE : DOM_SHA3;
`else
  assign dom = DOM_SHA3;
`endif

  // A last word arriving into an empty low half is parked in lo_q and
  // padded from PAD, so the input side never has to wait on the output.
  always_comb begin
    load     = 1'b0;
    fin_lane = 1'b0;
    pad_en   = 1'b0;
    pad_pos  = 3'd0;
    pk_lo    = lo_q;
    pk_hi    = in_data_i;
    case (st_q)
      ST_ABSORB: begin
        if (acc && lo_vld_q) begin
          load = 1'b1;
          if (in_last_i) begin
            if (nb_c != 3'd4) begin
              pad_en   = 1'b1;
              pad_pos  = {1'b1, nb_c[1:0]};
              fin_lane = 1'b1;
            end else begin
              // Full lane: the block is final unless this lane closes it.
              fin_lane = !at_end;
            end
          end
        end
      end
      ST_PAD: begin
        if (out_free && !fin_q) begin
          load     = 1'b1;
          fin_lane = 1'b1;
          pk_lo    = lo_vld_q ? lo_q : 32'h0;
          pk_hi    = 32'h0;
          pad_en   = lo_vld_q || pend_q;
          pad_pos  = lo_vld_q ? nb_q : 3'd0;
        end
      end
      default: ;
    endcase
  end

  keccak_lane_packer u_packer (
    .lo_i      (pk_lo),
    .hi_i      (pk_hi),
    .pad_en_i  (pad_en),
    .pad_pos_i (pad_pos),
    .domain_i  (dom),
    .msb_i     (fin_lane && at_end),
    .lane_o    (lane)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      st_q      <= ST_IDLE;
      mode_q    <= CM_SHA3_256;
      err_q     <= 1'b0;
      lo_q      <= '0;
      lo_vld_q  <= 1'b0;
      nb_q      <= '0;
      pend_q    <= 1'b0;
      fin_q     <= 1'b0;
      cnt_q     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      out_end_q <= 1'b0;
      out_lb_q  <= 1'b0;
    end else begin
      if (load) begin
        out_q     <= lane;
        out_vld_q <= 1'b1;
        out_end_q <= at_end;
        out_lb_q  <= fin_lane;
        cnt_q     <= at_end ? 7'd0 : cnt_q + 7'd1;
        if (fin_lane && at_end) fin_q <= 1'b1;
      end else if (out_ready_i) begin
        out_vld_q <= 1'b0;
      end

      case (st_q)
        ST_IDLE: begin
          if (start_i) begin
            if (mode_legal(cmode_i)) begin
              mode_q   <= cmode_e'(cmode_i);
              err_q    <= 1'b0;
              st_q     <= ST_ABSORB;
              cnt_q    <= '0;
              lo_vld_q <= 1'b0;
              pend_q   <= 1'b0;
              fin_q    <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_ABSORB: begin
          if (acc) begin
            if (!lo_vld_q) begin
              lo_q     <= in_data_i;
              lo_vld_q <= 1'b1;
              nb_q     <= nb_c;
            end else begin
              lo_vld_q <= 1'b0;
              pend_q   <= in_last_i && (nb_c == 3'd4);
            end
            if (in_last_i) st_q <= ST_PAD;
          end
        end
        ST_PAD: begin
          if (load) begin
            lo_vld_q <= 1'b0;
            pend_q   <= 1'b0;
          end
          if (fin_q || (load && at_end)) st_q <= ST_DONE;
        end
        ST_DONE: begin
          if (out_free) st_q <= ST_IDLE;
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  assign dout_0_o           = out_q[31:0];
  assign dout_1_o           = out_q[63:32];
  assign out_valid_o        = out_vld_q;
  assign out_block_end_o    = out_end_q;
  assign last_block_o       = out_lb_q;
  assign last_block_count_o = rate;
  assign busy_o             = (st_q != ST_IDLE);
  assign err_o              = err_q;

endmodule

// File: tb/tb_keccak_pad_feeder.sv
// Directed testbench for keccak_pad_feeder.
module tb_keccak_pad_feeder;

  logic        clk_i = 1'b0;
  logic        reset_i, start_i, in_valid_i, in_last_i, out_ready_i;
  logic [2:0]  cmode_i, in_nbytes_i;
  logic [31:0] in_data_i;
  logic        in_ready_o, out_valid_o, out_block_end_o, last_block_o, busy_o, err_o;
  logic [31:0] dout_0_o, dout_1_o;
  logic [6:0]  last_block_count_o;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  msg [0:255];
  logic [7:0]  eb  [0:511];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic        qe[$];
  logic        qlb[$];

  keccak_pad_feeder dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .cmode_i(cmode_i),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_last_i(in_last_i),
    .in_nbytes_i(in_nbytes_i), .in_ready_o(in_ready_o),
    .dout_0_o(dout_0_o), .dout_1_o(dout_1_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_block_end_o(out_block_end_o),
    .last_block_o(last_block_o), .last_block_count_o(last_block_count_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (!reset_i && out_valid_o && out_ready_i) begin
      q0.push_back(dout_0_o);
      q1.push_back(dout_1_o);
      qe.push_back(out_block_end_o);
      qlb.push_back(last_block_o);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic clear_q();
    q0.delete(); q1.delete(); qe.delete(); qlb.delete();
  endtask

  task automatic set_pattern(input int seed);
    for (int i = 0; i < 256; i++) msg[i] = 8'(i * 13 + seed);
  endtask

  task automatic do_start(input logic [2:0] m);
    start_i = 1'b1;
    cmode_i = m;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic send_msg(input int n, input logic [7:0] fill);
    int nw;
    nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      int t;
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = 4 * w + k;
        in_data_i[k*8 +: 8] = (idx < n) ? msg[idx] : fill;
      end
      in_last_i   = (w == nw - 1);
      in_nbytes_i = (w == nw - 1) ? 3'(n - 4 * w) : 3'd0;
      in_valid_i  = 1'b1;
      t = 0;
      @(negedge clk_i);
      while (!in_ready_o && t < 300) begin
        @(negedge clk_i);
        t++;
      end
      if (!in_ready_o) begin
        n_chk++; n_fail++;
        $display("FAIL send_timeout word %0d: in_ready_o=%0b required 1", w, in_ready_o);
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        return;
      end
      @(posedge clk_i); #1;
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk_i);
    while (busy_o && t < 2000) begin
      @(negedge clk_i);
      t++;
    end
    n_chk++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_timeout: busy_o=%0b required 0", busy_o);
    end
    @(posedge clk_i); #1;
  endtask

  // Reference pad10*1: message, domain byte, zeros, 0x80 ORed into the last byte.
  task automatic check_lanes(input string name, input int n, input int rate, input logic [7:0] dom);
    int nl;
    logic [31:0] e0, e1;
    nl = (n / (rate * 8) + 1) * rate;
    for (int i = 0; i < nl * 8; i++) eb[i] = (i < n) ? msg[i] : ((i == n) ? dom : 8'h00);
    eb[nl*8-1] = eb[nl*8-1] | 8'h80;
    n_chk++;
    if (q0.size() != nl) begin
      n_fail++;
      $display("FAIL %s lane_count: got %0d required %0d", name, q0.size(), nl);
    end
    for (int j = 0; j < nl && j < q0.size(); j++) begin
      e0 = {eb[8*j+3], eb[8*j+2], eb[8*j+1], eb[8*j]};
      e1 = {eb[8*j+7], eb[8*j+6], eb[8*j+5], eb[8*j+4]};
      n_chk++;
      if (q0[j] !== e0 || q1[j] !== e1) begin
        n_fail++;
        $display("FAIL %s lane%0d: got %h/%h required %h/%h", name, j, q0[j], q1[j], e0, e1);
      end
      n_chk++;
      if (qe[j] !== ((j % rate) == rate - 1)) begin
        n_fail++;
        $display("FAIL %s block_end lane%0d: got %0b required %0b", name, j, qe[j], ((j % rate) == rate - 1));
      end
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    n_chk++;
    if ({in_ready_o, out_valid_o, out_block_end_o, last_block_o, busy_o, err_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 000000",
               {in_ready_o, out_valid_o, out_block_end_o, last_block_o, busy_o, err_o});
    end
    n_chk++;
    if (dout_0_o !== 32'h0 || dout_1_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_dout: got %h/%h required 0/0", dout_0_o, dout_1_o);
    end
    n_chk++;
    if (last_block_count_o !== 7'd17) begin
      n_fail++;
      $display("FAIL reset_count: got %0d required 17", last_block_count_o);
    end
    @(posedge clk_i); #1;
    reset_i = 1'b0;
  endtask

  task automatic test_empty_256();
    set_pattern(1);
    clear_q();
    do_start(3'd1);
    send_msg(0, 8'hEE);
    wait_idle();
    check_lanes("empty256", 0, 17, 8'h06);
    if (q0.size() == 17) begin
      n_chk++;
      if (q0[0] !== 32'h00000006 || q1[0] !== 32'h0) begin
        n_fail++;
        $display("FAIL empty256 lane0: got %h/%h required 00000006/00000000", q0[0], q1[0]);
      end
      n_chk++;
      if (q0[16] !== 32'h0 || q1[16] !== 32'h80000000) begin
        n_fail++;
        $display("FAIL empty256 lane16: got %h/%h required 00000000/80000000", q0[16], q1[16]);
      end
    end
    for (int j = 0; j < q0.size(); j++) begin
      n_chk++;
      if (qlb[j] !== 1'b1) begin
        n_fail++;
        $display("FAIL empty256 last_block lane%0d: got %0b required 1", j, qlb[j]);
      end
    end
  endtask

  task automatic test_abc();
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    clear_q();
    do_start(3'd1);
    n_chk++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL abc busy: got %0b required 1", busy_o);
    end
    do_start(3'd3);
    n_chk++;
    if (last_block_count_o !== 7'd17) begin
      n_fail++;
      $display("FAIL abc start_ignored: count %0d required 17", last_block_count_o);
    end
    send_msg(3, 8'h00);
    wait_idle();
    check_lanes("abc", 3, 17, 8'h06);
    if (q0.size() > 0) begin
      n_chk++;
      if (q0[0] !== 32'h06636261 || q1[0] !== 32'h0) begin
        n_fail++;
        $display("FAIL abc lane0: got %h/%h required 06636261/00000000", q0[0], q1[0]);
      end
    end
  endtask

  task automatic test_sha512_71();
    set_pattern(5);
    clear_q();
    do_start(3'd3);
    n_chk++;
    if (last_block_count_o !== 7'd9) begin
      n_fail++;
      $display("FAIL sha512 count: got %0d required 9", last_block_count_o);
    end
    send_msg(71, 8'hEE);
    wait_idle();
    check_lanes("sha512_71", 71, 9, 8'h06);
    if (q0.size() == 9) begin
      n_chk++;
      if (q1[8][31:24] !== 8'h86 || qlb[8] !== 1'b1) begin
        n_fail++;
        $display("FAIL sha512 lane8: byte7 %h last_block %0b required 86/1", q1[8][31:24], qlb[8]);
      end
    end
  endtask

  task automatic test_boundary_136();
    set_pattern(9);
    clear_q();
    do_start(3'd1);
    send_msg(136, 8'hEE);
    wait_idle();
    check_lanes("b136", 136, 17, 8'h06);
    if (q0.size() == 34) begin
      n_chk++;
      if (q0[17] !== 32'h00000006 || q1[17] !== 32'h0 || q0[33] !== 32'h0 || q1[33] !== 32'h80000000) begin
        n_fail++;
        $display("FAIL b136 pad_block: lane17 %h/%h lane33 %h/%h required 00000006/0 0/80000000",
                 q0[17], q1[17], q0[33], q1[33]);
      end
      n_chk++;
      if (qlb[16] !== 1'b0) begin
        n_fail++;
        $display("FAIL b136 last_block lane16: got %0b required 0", qlb[16]);
      end
      for (int j = 17; j < 34; j++) begin
        n_chk++;
        if (qlb[j] !== 1'b1) begin
          n_fail++;
          $display("FAIL b136 last_block lane%0d: got %0b required 1", j, qlb[j]);
        end
      end
    end
  endtask

  task automatic test_stall();
    set_pattern(3);
    clear_q();
    do_start(3'd1);
    fork
      send_msg(100, 8'hEE);
      begin
        int t;
        logic [31:0] d0, d1;
        t = 0;
        while (q0.size() < 3 && t < 500) begin
          @(negedge clk_i);
          t++;
        end
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        t = 0;
        @(negedge clk_i);
        while (!out_valid_o && t < 20) begin
          @(negedge clk_i);
          t++;
        end
        d0 = dout_0_o;
        d1 = dout_1_o;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk_i);
          n_chk++;
          if (out_valid_o !== 1'b1 || dout_0_o !== d0 || dout_1_o !== d1) begin
            n_fail++;
            $display("FAIL stall_hold cycle %0d: valid %0b data %h/%h required 1 %h/%h",
                     c, out_valid_o, dout_0_o, dout_1_o, d0, d1);
          end
        end
        n_chk++;
        if (in_ready_o !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_in_ready: got %0b required 0", in_ready_o);
        end
        @(posedge clk_i); #1;
        out_ready_i = 1'b1;
      end
    join
    wait_idle();
    check_lanes("stall", 100, 17, 8'h06);
  endtask

  task automatic test_reset_mid();
    set_pattern(7);
    clear_q();
    do_start(3'd1);
    for (int w = 0; w < 30; w++) begin
      if (q0.size() >= 5) break;
      in_data_i   = {msg[4*w+3], msg[4*w+2], msg[4*w+1], msg[4*w]};
      in_last_i   = 1'b0;
      in_nbytes_i = 3'd0;
      in_valid_i  = 1'b1;
      @(posedge clk_i); #1;
    end
    in_valid_i = 1'b0;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    n_chk++;
    if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b0 || dout_0_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid idle: busy %0b valid %0b ready %0b dout0 %h required 0 0 0 0",
               busy_o, out_valid_o, in_ready_o, dout_0_o);
    end
    @(posedge clk_i); #1;
    clear_q();
    do_start(3'd0);
    n_chk++;
    if (last_block_count_o !== 7'd18) begin
      n_fail++;
      $display("FAIL reset_mid count: got %0d required 18", last_block_count_o);
    end
    send_msg(0, 8'hEE);
    wait_idle();
    check_lanes("sha224_empty", 0, 18, 8'h06);
  endtask

  task automatic test_illegal();
    clear_q();
`ifdef KECCAK_PAD_SHAKE_EN
    do_start(3'd4);
    n_chk++;
    if (err_o !== 1'b0 || busy_o !== 1'b1 || last_block_count_o !== 7'd21) begin
      n_fail++;
      $display("FAIL shake128 start: err %0b busy %0b count %0d required 0 1 21",
               err_o, busy_o, last_block_count_o);
    end
    send_msg(0, 8'hEE);
    wait_idle();
    check_lanes("shake128", 0, 21, 8'h1F);
    clear_q();
`else
    do_start(3'd4);
    n_chk++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL cmode4: err %0b busy %0b required 1 0", err_o, busy_o);
    end
`endif
    do_start(3'd6);
    repeat (5) @(posedge clk_i);
    #1;
    n_chk++;
    if (err_o !== 1'b1 || busy_o !== 1'b0 || out_valid_o !== 1'b0 || q0.size() != 0) begin
      n_fail++;
      $display("FAIL cmode6: err %0b busy %0b valid %0b lanes %0d required 1 0 0 0",
               err_o, busy_o, out_valid_o, q0.size());
    end
    do_start(3'd1);
    n_chk++;
    if (err_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL err_clear: err %0b busy %0b required 0 1", err_o, busy_o);
    end
    send_msg(0, 8'hEE);
    wait_idle();
  endtask

  initial begin
    reset_i = 1'b1; start_i = 1'b0; cmode_i = 3'd0;
    in_data_i = 32'h0; in_valid_i = 1'b0; in_last_i = 1'b0; in_nbytes_i = 3'd0;
    out_ready_i = 1'b1;
    test_reset();
    test_empty_256();
    test_abc();
    test_sha512_71();
    test_boundary_136();
    test_stall();
    test_reset_mid();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/keccak_pad_feeder.md
KECCAK_PAD_FEEDER -- requirements
Module: keccak_pad_feeder

Interface
REQ-001 The module SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- clk_i  in  1  clock
- reset_i  in  1  synchronous reset, active-high
- start_i  in  1  begin message; latches cmode_i
- cmode_i  in  3  mode: 0 SHA3-224, 1 SHA3-256, 2 SHA3-384, 3 SHA3-512, 4 SHAKE128, 5 SHAKE256
- in_data_i  in  32  message word; byte 0 in bits 7:0
- in_valid_i  in  1  word valid
- in_last_i  in  1  final word of message
- in_nbytes_i  in  3  valid bytes on final word, 0..4; 0 means empty word
- in_ready_o  out  1  word accepted when in_valid_i and in_ready_o are both high
- dout_0_o  out  32  lane bits 31:0, the earlier word
- dout_1_o  out  32  lane bits 63:32
- out_valid_o, out_ready_i  out/in  1  lane handshake
- out_block_end_o  out  1  current lane is the last lane of a rate block
- last_block_o  out  1  current lane belongs to the final padded block
- last_block_count_o  out  7  rate in lanes for the latched mode
- busy_o, err_o  out  1  message in progress; illegal cmode latched

Function
REQ-003 Rate in lanes SHALL be 18/17/13/9/21/17 for cmode 0..5; domain byte SHALL be 0x06 for SHA3 and 0x1F for SHAKE.
REQ-004 The FSM SHALL have states IDLE, ABSORB, PAD, DONE; start_i in IDLE moves to ABSORB; start_i outside IDLE SHALL be ignored.
REQ-005 ABSORB SHALL pack two accepted words per lane into a one-lane output register; a lane SHALL appear on out_valid_o the cycle after its second word is accepted.
REQ-006 in_ready_o SHALL be high in ABSORB when the low-half register is empty, or when the output register is empty or drained in the same cycle.
REQ-007 out_valid_o SHALL hold until out_ready_i; dout_0_o and dout_1_o SHALL stay stable while stalled.
REQ-008 On accepting in_last_i, the pad byte SHALL be placed at the first unused byte of the lane, with the remaining lane bytes zero; the FSM SHALL move to PAD.
REQ-009 The lane with lane index rate-1 SHALL have bit 63 ORed to 1. When the pad byte falls in byte 7 of that lane, the byte SHALL be 0x86 or 0x9F.
REQ-010 PAD SHALL emit zero lanes until lane index rate-1, then enter DONE. A message ending exactly on a block boundary SHALL produce one full extra padding block.
REQ-011 A lane counter SHALL run 0..rate-1 and wrap to 0 after out_block_end_o is accepted; last_block_o SHALL be high for every lane of the final block.
REQ-012 DONE SHALL return to IDLE the cycle after the final lane is accepted; busy_o SHALL be high in ABSORB, PAD and DONE.
REQ-013 cmode 6 or 7 SHALL set err_o, stay in IDLE, and emit nothing; err_o SHALL clear on the next legal start_i.

Reset
REQ-014 reset_i SHALL return the FSM to IDLE and clear all counters and lane registers, even mid-message.
REQ-015 Under reset, every output SHALL be 0 except last_block_count_o, which SHALL be 17.

Configuration
REQ-016 With KECCAK_PAD_SHAKE_EN defined, cmode 4 and 5 SHALL be legal. Without it, cmode 4 and 5 SHALL be handled as in REQ-013, and the 0x1F path SHALL be removed.

Structure
REQ-017 A shared package keccak_pkg SHALL hold the cmode enum, the rate table function, the domain byte constants and the FSM state typedef.
REQ-018 A sub-module keccak_lane_packer SHALL handle word-to-lane packing and pad-byte insertion.

Verification
REQ-019 SHA3-256, one word with in_last_i=1 and in_nbytes_i=0 -> 17 lanes: lane0 0x00000006/0x00000000, lane16 0x00000000/0x80000000, last_block_o high on all 17 lanes.
REQ-020 SHA3-256 "abc": in_data_i=0x00636261, in_nbytes_i=3 -> lane0 dout_0_o=0x06636261, dout_1_o=0; 17 lanes in total.
REQ-021 SHA3-512, 71 bytes -> 9 lanes; lane8 dout_1_o byte 3 = 0x86.
REQ-022 SHA3-256, 136 bytes -> 34 lanes; the second block is lane0 0x00000006/0 through lane16 0/0x80000000; out_block_end_o on lanes 16 and 33.
REQ-023 out_ready_i held low for 5 cycles mid-block -> output data stable, in_ready_o low after one buffered word, no lane lost or duplicated.
REQ-024 reset_i pulsed at lane 5 of a message -> IDLE next cycle; a following SHA3-224 empty message yields exactly 18 lanes. Without KECCAK_PAD_SHAKE_EN, cmode=4 -> err_o=1, no output.
